image_packet_loader: RTL and testbench

Upstream feeder for the network's control unit. Consumes the byte stream from the UART receiver and parses one packet: command byte, label byte, then NUM_PIX pixel bytes. Assembles the packed image vector and label, then pulses start (and train, for training packets) into the control unit. It holds the image stable and refuses new bytes until the control unit's ack.

---
 rtl/image_packet_loader.sv | 144 ++++++++++++++
 tb/tb_image_packet_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_packet_loader.sv
// image_packet_loader
//   Parses one packet from the UART byte stream: a command byte, a label byte,
//   then NUM_PIX pixel bytes. It assembles the packed image and the label, then
//   pulses start (and train, for train packets) toward the control unit. After
//   that it holds the image and refuses new bytes until the control unit sends ack.
//
// Ports
//   clk      : single clock, posedge
//   rst      : asynchronous, active-high reset
//   rx_data  : byte from the UART receiver
//   rx_valid : one-cycle strobe, rx_data valid this cycle
//   ack      : one-cycle pulse, control unit finished the current packet
//   rx_ready : a byte offered this cycle will be consumed (decoded from state)
//   start    : one-cycle pulse, packet complete
//   train    : one-cycle pulse with start, train packets only
//   label    : label byte of the current packet
//   image    : pixel k (arrival order) at image[8k+7:8k]
//   busy     : high from accepted command byte until ack
//   err      : one-cycle pulse on a protocol error
//   overrun  : sticky, a byte arrived while rx_ready was low
module image_packet_loader #(
  parameter int          NUM_PIX      = 784,
  parameter int          IMG_SZ       = NUM_PIX << 3,
  parameter logic [7:0]  CMD_CLASSIFY = 8'h43,
  parameter logic [7:0]  CMD_TRAIN    = 8'h54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              ack,
  output logic              rx_ready,
  output logic              start,
  output logic              train,
  output logic [7:0]        label,
  output logic [IMG_SZ-1:0] image,
  output logic              busy,
  output logic              err,
  output logic              overrun
);

  localparam int CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_LABEL,
    GET_PIX,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic             is_train;

  // Bytes are accepted while a packet is being collected; once complete, the
  // image is frozen until the control unit acknowledges it.
  assign rx_ready = (state == IDLE) || (state == GET_LABEL) || (state == GET_PIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      is_train <= 1'b0;
      image    <= '0;
      label    <= '0;
      start    <= 1'b0;
      train    <= 1'b0;
      err      <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start <= 1'b0;
      train <= 1'b0;
      err   <= 1'b0;

      // Bytes offered while not ready are dropped but remembered.
      if (rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if ((rx_data == CMD_CLASSIFY) || (rx_data == CMD_TRAIN)) begin
              is_train <= (rx_data == CMD_TRAIN);
              overrun  <= 1'b0;
              busy     <= 1'b1;
              state    <= GET_LABEL;
            end else begin
              err <= 1'b1;
            end
          end
        end

        GET_LABEL: begin
          if (rx_valid) begin
            label <= rx_data;
            // Train labels are digit classes; anything above 9 aborts the packet.
            if (is_train && (rx_data > 8'd9)) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pix_cnt <= '0;
              state   <= GET_PIX;
            end
          end
        end

        GET_PIX: begin
          if (rx_valid) begin
            image[{pix_cnt, 3'b000} +: 8] <= rx_data;
            if (pix_cnt == LAST_PIX) begin
              start <= 1'b1;
              train <= is_train;
              state <= ISSUE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end

        ISSUE: begin
          state <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_packet_loader.sv
// tb_image_packet_loader
//   Bench for image_packet_loader with a 4-pixel image: a table of whole
//   transactions, hand-written overrun and reset sequences, and randomized
//   packets checked against a byte-array model of the image and label.
module tb_image_packet_loader;

  localparam int NP  = 4;
  localparam int IMG = NP * 8;

  logic           clk;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           ack;
  logic           rx_ready;
  logic           start;
  logic           train;
  logic [7:0]     label;
  logic [IMG-1:0] image;
  logic           busy;
  logic           err;
  logic           overrun;

  image_packet_loader #(.NUM_PIX(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ack      (ack),
    .rx_ready (rx_ready),
    .start    (start),
    .train    (train),
    .label    (label),
    .image    (image),
    .busy     (busy),
    .err      (err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  int             start_cnt;
  int             train_cnt;
  int             err_cnt;
  logic [IMG-1:0] img_at_start;
  logic [7:0]     lbl_at_start;

  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        start_cnt    = start_cnt + 1;
        img_at_start = image;
        lbl_at_start = label;
      end
      if (train) train_cnt = train_cnt + 1;
      if (err)   err_cnt   = err_cnt + 1;
    end
  end

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              exp_start;
    int              exp_train;
    int              exp_err;
    logic [31:0]     exp_image;
    logic [7:0]      exp_label;
  } vec_t;

  vec_t vecs[7];

  // Behavioural model for the randomized section
  logic [7:0] m_pix[NP];
  logic [7:0] m_label;
  logic       m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic clear_counts();
    start_cnt = 0;
    train_cnt = 0;
    err_cnt   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] model_image();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[8*k +: 8] = m_pix[k];
    return v;
  endfunction

  task automatic apply_vec(input int i);
    clear_counts();
    for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
    sync_neg();
    if (vecs[i].exp_start != 0) begin
      tick();
      chk($sformatf("v%0d_busy_wait", i), {31'b0, busy}, 32'd1);
      repeat (3) tick();
      pulse_ack();
    end else begin
      repeat (2) tick();
    end
    chk($sformatf("v%0d_start_cnt", i), start_cnt, vecs[i].exp_start);
    chk($sformatf("v%0d_train_cnt", i), train_cnt, vecs[i].exp_train);
    chk($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
    chk($sformatf("v%0d_image", i), image, vecs[i].exp_image);
    chk($sformatf("v%0d_label", i), {24'b0, label}, {24'b0, vecs[i].exp_label});
    chk($sformatf("v%0d_busy_idle", i), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    ack         = 1'b0;
    clear_counts();

    vecs[0] = '{{8'h43, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00}, 6, 1, 0, 0, 32'h44332211, 8'h07};
    vecs[1] = '{{8'h54, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00}, 6, 1, 1, 0, 32'hDDCCBBAA, 8'h03};
    vecs[2] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 1, 32'hDDCCBBAA, 8'h03};
    vecs[3] = '{{8'h54, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 0, 1, 32'hDDCCBBAA, 8'h0A};
    vecs[4] = '{{8'h43, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00}, 6, 1, 0, 0, 32'h04030201, 8'hFF};
    vecs[5] = '{{8'h54, 8'h09, 8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00}, 6, 1, 1, 0, 32'hFF00A55A, 8'h09};
    vecs[6] = '{{8'h12, 8'h54, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00}, 7, 1, 1, 1, 32'h40302010, 8'h00};

    // Reset state
    repeat (2) tick();
    chk("rst_image", image, 32'h0);
    chk("rst_label", {24'b0, label}, 32'h0);
    chk("rst_ctrl", {27'b0, start, train, err, overrun, busy}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);

    // Table of whole transactions
    for (int i = 0; i < 7; i++) apply_vec(i);

    // Overrun during WAIT_ACK
    clear_counts();
    send_byte(8'h43); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    chk("ovr_ready_issue", {31'b0, rx_ready}, 32'd0);
    tick();
    chk("ovr_ready_wait", {31'b0, rx_ready}, 32'd0);
    send_byte(8'hEE);
    chk("ovr_ready_b1", {31'b0, rx_ready}, 32'd0);
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    send_byte(8'hEF);
    chk("ovr_ready_b2", {31'b0, rx_ready}, 32'd0);
    chk("ovr_image", image, 32'h40302010);
    pulse_ack();
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);
    tick();
    send_byte(8'h43);
    chk("ovr_cleared", {31'b0, overrun}, 32'd0);
    send_byte(8'h02);
    send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h0E); send_byte(8'h0F);
    tick();
    pulse_ack();
    chk("ovr_next_image", image, 32'h0F0E0D0C);
    chk("ovr_start_cnt", start_cnt, 2);

    // Asynchronous reset in the middle of a packet
    clear_counts();
    send_byte(8'h43); send_byte(8'h05); send_byte(8'h77); send_byte(8'h88);
    rst = 1'b1;
    #1;
    chk("mid_rst_image", image, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_label", {24'b0, label}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_start", start_cnt, 0);
    send_byte(8'h54); send_byte(8'h08);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    sync_neg();
    tick();
    pulse_ack();
    chk("post_rst_start", start_cnt, 1);
    chk("post_rst_train", train_cnt, 1);
    chk("post_rst_image", image, 32'hC4C3C2C1);
    chk("post_rst_label", {24'b0, label}, 32'h08);

    // Randomized packets against the model
    do_reset();
    for (int k = 0; k < NP; k++) m_pix[k] = 8'h00;
    m_label = 8'h00;
    m_ovr   = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int         kind;
      int         exp_err;
      logic [7:0] b;
      logic [7:0] pix[NP];
      kind    = $urandom_range(0, 3);
      exp_err = 0;
      clear_counts();
      if (kind <= 1) begin
        logic is_tr;
        int   inj;
        is_tr = (kind == 1);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(is_tr ? 8'h54 : 8'h43);
        m_ovr = 1'b0;
        b = is_tr ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 2)) tick();
        send_byte(b);
        for (int k = 0; k < NP; k++) begin
          pix[k] = 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) tick();
          send_byte(pix[k]);
        end
        m_label = b;
        for (int k = 0; k < NP; k++) m_pix[k] = pix[k];
        sync_neg();
        chk($sformatf("r%0d_start", it), start_cnt, 1);
        chk($sformatf("r%0d_train", it), train_cnt, is_tr ? 1 : 0);
        chk($sformatf("r%0d_img_at_start", it), img_at_start, model_image());
        chk($sformatf("r%0d_lbl_at_start", it), {24'b0, lbl_at_start}, {24'b0, m_label});
        tick();
        inj = $urandom_range(0, 2);
        for (int j = 0; j < inj; j++) begin
          send_byte(8'($urandom_range(0, 255)));
          m_ovr = 1'b1;
        end
        repeat ($urandom_range(0, 3)) tick();
        pulse_ack();
        chk($sformatf("r%0d_busy", it), {31'b0, busy}, 32'd0);
      end else if (kind == 2) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h43 || b == 8'h54);
        send_byte(b);
        exp_err = 1;
        sync_neg();
        chk($sformatf("r%0d_busy", it), {31'b0, busy}, 32'd0);
      end else begin
        send_byte(8'h54);
        m_ovr = 1'b0;
        b = 8'($urandom_range(10, 255));
        send_byte(b);
        m_label = b;
        exp_err = 1;
        sync_neg();
        chk($sformatf("r%0d_start", it), start_cnt, 0);
        chk($sformatf("r%0d_busy", it), {31'b0, busy}, 32'd0);
      end
      tick();
      chk($sformatf("r%0d_err", it), err_cnt, exp_err);
      chk($sformatf("r%0d_image", it), image, model_image());
      chk($sformatf("r%0d_label", it), {24'b0, label}, {24'b0, m_label});
      chk($sformatf("r%0d_overrun", it), {31'b0, overrun}, {31'b0, m_ovr});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
